// File: rtl/stack_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : stack_sequencer
// Purpose  : Turns decoder stack requests into stack-pointer controls, stack
//            RAM accesses, popped data and PC redirects. Also tracks depth.
// Revision : 1.0
// ============================================================================
module stack_sequencer #(
    parameter logic [7:0] SP_INIT   = 8'hFF,
    parameter int         DEPTH_MAX = 256
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       op_valid,
    input  logic [2:0] op,
    input  logic [7:0] op_data,
    input  logic [7:0] op_target,
    output logic       op_ready,
    input  logic [7:0] SP_address,
    output logic       I_SP,
    output logic       D_SP,
    output logic [7:0] R0_out,
    output logic [7:0] mem_addr,
    output logic [7:0] mem_wdata,
    output logic       mem_we,
    output logic       mem_re,
    input  logic [7:0] mem_rdata,
    output logic [7:0] pop_data,
    output logic       pop_valid,
    output logic       pc_load,
    output logic [7:0] pc_target,
    output logic [8:0] depth,
    output logic       ovf,
    output logic       unf
);

    localparam logic [2:0] c_st_init     = 3'd0;
    localparam logic [2:0] c_st_idle     = 3'd1;
    localparam logic [2:0] c_st_push     = 3'd2;
    localparam logic [2:0] c_st_pop_rd   = 3'd3;
    localparam logic [2:0] c_st_pop_wait = 3'd4;

    localparam logic [2:0] c_op_push = 3'd1;
    localparam logic [2:0] c_op_pop  = 3'd2;
    localparam logic [2:0] c_op_call = 3'd3;
    localparam logic [2:0] c_op_ret  = 3'd4;
    localparam logic [2:0] c_op_ldsp = 3'd5;

    localparam logic [8:0] c_depth_max = 9'(DEPTH_MAX);

    logic [2:0] r_state;
    logic [2:0] r_op;
    logic [7:0] r_data;
    logic [7:0] r_target;
    logic [7:0] r_pop_data;
    logic       r_pop_valid;
    logic       r_pc_load;
    logic [7:0] r_pc_target;
    logic [8:0] r_depth;
    logic       r_ovf;
    logic       r_unf;

    logic w_is_ldsp;
    logic w_is_call;
    logic w_is_ret;

    assign w_is_ldsp = (r_op == c_op_ldsp);
    assign w_is_call = (r_op == c_op_call);
    assign w_is_ret  = (r_op == c_op_ret);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_st_init;
            r_op        <= 3'd0;
            r_data      <= 8'h00;
            r_target    <= 8'h00;
            r_pop_data  <= 8'h00;
            r_pop_valid <= 1'b0;
            r_pc_load   <= 1'b0;
            r_pc_target <= 8'h00;
            r_depth     <= 9'd0;
            r_ovf       <= 1'b0;
            r_unf       <= 1'b0;
        end else begin
            r_pop_valid <= 1'b0;
            r_pc_load   <= 1'b0;
            case (r_state)
                c_st_init: r_state <= c_st_idle;
                c_st_idle: begin
                    if (op_valid) begin
                        r_op     <= op;
                        r_data   <= op_data;
                        r_target <= op_target;
                        case (op)
                            c_op_push, c_op_call, c_op_ldsp: r_state <= c_st_push;
                            c_op_pop, c_op_ret:              r_state <= c_st_pop_rd;
                            default:                         r_state <= c_st_idle;
                        endcase
                    end
                end
                // LDSP reuses the PUSH slot as a pointer reload with no RAM write
                c_st_push: begin
                    r_state <= c_st_idle;
                    if (w_is_ldsp) begin
                        r_depth <= 9'd0;
                        r_ovf   <= 1'b0;
                        r_unf   <= 1'b0;
                    end else begin
                        if (r_depth == c_depth_max) r_ovf <= 1'b1;
                        else                        r_depth <= r_depth + 9'd1;
                        if (w_is_call) begin
                            r_pc_load   <= 1'b1;
                            r_pc_target <= r_target;
                        end
                    end
                end
                c_st_pop_rd: begin
                    r_state <= c_st_pop_wait;
                    if (r_depth == 9'd0) r_unf   <= 1'b1;
                    else                 r_depth <= r_depth - 9'd1;
                end
                c_st_pop_wait: begin
                    r_state     <= c_st_idle;
                    r_pop_data  <= mem_rdata;
                    r_pop_valid <= 1'b1;
                    if (w_is_ret) begin
                        r_pc_load   <= 1'b1;
                        r_pc_target <= mem_rdata;
                    end
                end
                default: r_state <= c_st_init;
            endcase
        end
    end

    assign op_ready  = (r_state == c_st_idle);
    assign I_SP      = (r_state == c_st_init) || (r_state == c_st_push);
    assign D_SP      = (r_state == c_st_init) || (r_state == c_st_pop_rd) ||
                       ((r_state == c_st_push) && w_is_ldsp);
    assign R0_out    = (r_state == c_st_init) ? SP_INIT : r_data;
    assign mem_addr  = SP_address;
    assign mem_wdata = r_data;
    assign mem_we    = (r_state == c_st_push) && !w_is_ldsp;
    assign mem_re    = (r_state == c_st_pop_rd);

    assign pop_data  = r_pop_data;
    assign pop_valid = r_pop_valid;
    assign pc_load   = r_pc_load;
    assign pc_target = r_pc_target;
    assign depth     = r_depth;
    assign ovf       = r_ovf;
    assign unf       = r_unf;

endmodule
`default_nettype wire
